// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider: valid/ready in, valid/ready out.
// master drives operands and consumes results; slave is the divider.
interface seq_divider_if #(
    parameter int N = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   Dividend;
    logic [N-1:0]     Divisor;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     Quotient;
    logic [N-1:0]     Remainder;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, Dividend, Divisor, out_ready,
        input  in_ready, out_valid, Quotient, Remainder, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, Dividend, Divisor, out_ready,
        output in_ready, out_valid, Quotient, Remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring radix-2 divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Divide-by-zero and quotient overflow are detected at accept and skip the iteration.
module seq_divider #(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_reg;
    logic [N:0]      r_reg;
    logic [N-1:0]    q_reg;
    logic [N-1:0]    divisor_reg;
    logic [CW-1:0]   count_reg;
    logic            ovf_pend_reg;
    logic            dz_pend_reg;

    logic            in_ready_reg;
    logic            out_valid_reg;
    logic [N-1:0]    quotient_reg;
    logic [N-1:0]    remainder_reg;
    logic            overflow_reg;
    logic            div_by_zero_reg;

    // One restoring step: shift {R,Q} left, trial-subtract the divisor with an
    // extra guard bit so the top bit of the difference is the borrow.
    logic [N:0]      shift_r;
    logic [N+1:0]    trial;
    logic            borrow;

    assign shift_r = {r_reg[N-1:0], q_reg[N-1]};
    assign trial   = {1'b0, shift_r} - {2'b00, divisor_reg};
    assign borrow  = trial[N+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            r_reg           <= '0;
            q_reg           <= '0;
            divisor_reg     <= '0;
            count_reg       <= '0;
            ovf_pend_reg    <= 1'b0;
            dz_pend_reg     <= 1'b0;
            in_ready_reg    <= 1'b0;
            out_valid_reg   <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            overflow_reg    <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    out_valid_reg <= 1'b0;
                    if (bus.in_valid && in_ready_reg) begin
                        in_ready_reg <= 1'b0;
                        divisor_reg  <= bus.Divisor;
                        count_reg    <= '0;
                        if (bus.Divisor == '0) begin
                            state_reg    <= DONE;
                            dz_pend_reg  <= 1'b1;
                            ovf_pend_reg <= 1'b0;
                            q_reg        <= '1;
                            r_reg        <= {1'b0, bus.Dividend[N-1:0]};
                        end else if (bus.Dividend[2*N-1:N] >= bus.Divisor) begin
                            state_reg    <= DONE;
                            dz_pend_reg  <= 1'b0;
                            ovf_pend_reg <= 1'b1;
                            q_reg        <= '1;
                            r_reg        <= {1'b0, bus.Dividend[N-1:0]};
                        end else begin
                            state_reg    <= CALC;
                            dz_pend_reg  <= 1'b0;
                            ovf_pend_reg <= 1'b0;
                            q_reg        <= bus.Dividend[N-1:0];
                            r_reg        <= {1'b0, bus.Dividend[2*N-1:N]};
                        end
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end

                CALC: begin
                    in_ready_reg <= 1'b0;
                    if (borrow) begin
                        r_reg <= shift_r;
                        q_reg <= {q_reg[N-2:0], 1'b0};
                    end else begin
                        r_reg <= trial[N:0];
                        q_reg <= {q_reg[N-2:0], 1'b1};
                    end
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == CW'(N - 1)) begin
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    in_ready_reg <= 1'b0;
                    // First DONE cycle publishes the result; outputs then stay
                    // frozen until the consumer takes them.
                    if (!out_valid_reg) begin
                        out_valid_reg   <= 1'b1;
                        quotient_reg    <= q_reg;
                        remainder_reg   <= r_reg[N-1:0];
                        overflow_reg    <= ovf_pend_reg;
                        div_by_zero_reg <= dz_pend_reg;
                    end else if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.Quotient    = quotient_reg;
    assign bus.Remainder   = remainder_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.div_by_zero = div_by_zero_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, results, flags, output hold, mid-run reset.
module tb_seq_divider;
    localparam int N = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair, measure latency, check the result, then consume it
    // after 'stall' cycles of out_ready=0.
    task automatic run_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic eo, input logic ez, input int elat, input int stall);
        int lat;
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.Dividend = dvd;
        bus.Divisor  = dvs;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.Dividend = ~dvd;
        bus.Divisor  = ~dvs;
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, lat, elat);
        for (int i = 0; i < stall; i++) tick();
        check({tag, "_quotient"}, {16'd0, bus.Quotient}, {16'd0, eq});
        check({tag, "_remainder"}, {16'd0, bus.Remainder}, {16'd0, er});
        check({tag, "_flags"}, {30'd0, bus.overflow, bus.div_by_zero}, {30'd0, eo, ez});
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_drained"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        $display("txn %s: %0h / %0h -> q=%0h r=%0h ovf=%0b dz=%0b lat=%0d", tag, dvd, dvs,
                 bus.Quotient, bus.Remainder, bus.overflow, bus.div_by_zero, lat);
    endtask

    initial begin
        logic [15:0] q_hold;
        logic [15:0] r_hold;
        logic [31:0] rd;
        logic [15:0] rs;
        logic [15:0] eq;
        logic [15:0] er;
        logic        eo;
        logic        ez;
        int          wait_cnt;

        total = 0;
        bad   = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Dividend  = '0;
        bus.Divisor   = '0;
        rst = 1'b1;
        #1;
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("reset_outputs", {bus.Quotient, bus.Remainder}, 32'd0);
        check("reset_flags", {29'd0, bus.out_valid, bus.overflow, bus.div_by_zero}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        run_div("div_100000_7", 32'd100000, 16'd7, 16'h37CD, 16'd5, 1'b0, 1'b0, 17, 0);
        run_div("div_max", 32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 1'b0, 17, 0);
        run_div("div_6_7", 32'd6, 16'd7, 16'd0, 16'd6, 1'b0, 1'b0, 17, 0);
        run_div("ovf", 32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1, 0);
        run_div("dz", 32'h1234ABCD, 16'h0000, 16'hFFFF, 16'hABCD, 1'b0, 1'b1, 1, 0);
        run_div("div_1000_10", 32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b0, 17, 0);

        // Hold the result with out_ready low while poking the input side.
        bus.Dividend = 32'd100000;
        bus.Divisor  = 16'd7;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_cnt = 0;
        while (!bus.out_valid && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        check("hold_valid_seen", {31'd0, bus.out_valid}, 32'd1);
        q_hold = 16'h37CD;
        r_hold = 16'd5;
        for (int i = 0; i < 10; i++) begin
            bus.Dividend = 32'h00000009 + i;
            bus.Divisor  = 16'd3;
            bus.in_valid = i[0];
            tick();
            check("hold_stable", {bus.Quotient, bus.Remainder}, {q_hold, r_hold});
            check("hold_busy", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hold_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        $display("txn hold: q=%0h r=%0h held 10 cycles", q_hold, r_hold);

        // Reset in the middle of an iteration.
        bus.Dividend = 32'd100000;
        bus.Divisor  = 16'd7;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #1;
        check("midreset_outputs", {bus.Quotient, bus.Remainder}, 32'd0);
        check("midreset_ctrl", {28'd0, bus.in_ready, bus.out_valid, bus.overflow, bus.div_by_zero}, 32'd0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        wait_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) wait_cnt++;
            tick();
        end
        check("midreset_no_stale", wait_cnt, 0);
        $display("txn midreset: abandoned 100000/7, stale out_valid cycles=%0d", wait_cnt);
        run_div("after_reset", 32'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b0, 17, 0);

        // Small randomized sweep against integer division.
        for (int k = 0; k < 40; k++) begin
            rs = (k % 9 == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            rd = $urandom;
            if (k % 7 != 3 && rs != 0) rd[31:16] = 16'($urandom_range(0, int'(rs) - 1));
            ez = (rs == 0);
            eo = !ez && (rd[31:16] >= rs);
            if (ez || eo) begin
                eq = 16'hFFFF;
                er = rd[15:0];
            end else begin
                eq = 16'(rd / {16'd0, rs});
                er = 16'(rd % {16'd0, rs});
            end
            run_div("rand", rd, rs, eq, er, eo, ez, (ez || eo) ? 1 : 17, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
